yolo_box_feeder: RTL

- Sequencer driving the YOLO box-decode PE (sigmoid/exp/grid-offset pipeline) from the feature-map output buffer.
- Walks every grid cell (m, n) and anchor a of one detection layer and fetches the raw {tx, ty, tw, th} word for each.
- Presents each word to the PE with a packed data_parameter {anchor, n, m} and a one-cycle valid.
- Delays the valid and parameter by the PE pipeline depth so downstream logic knows when decoded results appear.

---
 rtl/yolo_box_feeder.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/yolo_box_feeder.sv
// Sequencer feeding raw YOLO box words to the box-decode PE.
// Define YOLO_FEEDER_HOLD_EN to hold PE inputs between valid cycles.
module yolo_box_feeder #(
    parameter int Data_bit   = 16,
    parameter int ADDR_W     = 16,
    parameter int PE_LATENCY = 6
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            cfg_grid_w,
    input  logic [3:0]            cfg_grid_h,
    input  logic [3:0]            cfg_anchor_num,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    output logic                  rd_req,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic                  rd_gnt,
    input  logic                  rd_valid,
    input  logic [4*Data_bit-1:0] rd_data,
    output logic [Data_bit-1:0]   data_parameter,
    output logic [Data_bit-1:0]   data_in_bx0,
    output logic [Data_bit-1:0]   data_in_by0,
    output logic [Data_bit-1:0]   data_in_bw0,
    output logic [Data_bit-1:0]   data_in_bh0,
    output logic                  pe_in_valid,
    output logic                  pe_out_valid,
    output logic [Data_bit-1:0]   pe_out_param,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;

    localparam int CW = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(PE_LATENCY - 1);

    state_t              state_q, state_d;
    logic [3:0]          w_q, w_d, h_q, h_d, an_q, an_d;
    logic [3:0]          a_q, a_d, m_q, m_d, n_q, n_d;
    logic [CW-1:0]       drn_q, drn_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                req_q, req_d;
    logic [Data_bit-1:0] bx_q, bx_d, by_q, by_d;
    logic [Data_bit-1:0] bw_q, bw_d, bh_q, bh_d;
    logic [Data_bit-1:0] par_q, par_d;
    logic                vld_q, vld_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                last_a, last_m, last_n;

    logic [PE_LATENCY-1:0] dv_q;
    logic [Data_bit-1:0]   dp_q [PE_LATENCY];

    assign last_a = (a_q == an_q - 4'd1);
    assign last_m = (m_q == w_q - 4'd1);
    assign last_n = (n_q == h_q - 4'd1);

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        an_d    = an_q;
        a_d     = a_q;
        m_d     = m_q;
        n_d     = n_q;
        drn_d   = drn_q;
        addr_d  = addr_q;
        vld_d   = 1'b0;
`ifdef YOLO_FEEDER_HOLD_EN
        bx_d    = bx_q;
        by_d    = by_q;
        bw_d    = bw_q;
        bh_d    = bh_q;
        par_d   = par_q;
`else
        bx_d    = '0;
        by_d    = '0;
        bw_d    = '0;
        bh_d    = '0;
        par_d   = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    w_d  = cfg_grid_w;
                    h_d  = cfg_grid_h;
                    an_d = cfg_anchor_num;
                    if (cfg_grid_w == 4'd0 || cfg_grid_h == 4'd0 ||
                        cfg_anchor_num == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        a_d     = '0;
                        m_d     = '0;
                        n_d     = '0;
                        addr_d  = cfg_base_addr;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (rd_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (rd_valid) begin
                    bx_d   = rd_data[Data_bit-1:0];
                    by_d   = rd_data[2*Data_bit-1:Data_bit];
                    bw_d   = rd_data[3*Data_bit-1:2*Data_bit];
                    bh_d   = rd_data[4*Data_bit-1:3*Data_bit];
                    par_d  = Data_bit'({a_q, n_q, m_q});
                    vld_d  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    // anchor innermost, then column, then row
                    if (last_a) begin
                        a_d = '0;
                        if (last_m) begin
                            m_d = '0;
                            n_d = n_q + 4'd1;
                        end else begin
                            m_d = m_q + 4'd1;
                        end
                    end else begin
                        a_d = a_q + 4'd1;
                    end
                    if (last_a && last_m && last_n) begin
                        drn_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            DRAIN: begin
                if (drn_q == DRAIN_LAST) state_d = DONE;
                else drn_d = drn_q + CW'(1);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_d  = (state_d == REQ);
        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            an_q    <= '0;
            a_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
            drn_q   <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            bx_q    <= '0;
            by_q    <= '0;
            bw_q    <= '0;
            bh_q    <= '0;
            par_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            an_q    <= an_d;
            a_q     <= a_d;
            m_q     <= m_d;
            n_q     <= n_d;
            drn_q   <= drn_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            bw_q    <= bw_d;
            bh_q    <= bh_d;
            par_q   <= par_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Mirrors the PE pipeline so results can be tagged downstream
    always_ff @(posedge M_AXI_ACLK) begin
        if (rst) begin
            dv_q <= '0;
            for (int i = 0; i < PE_LATENCY; i++) dp_q[i] <= '0;
        end else begin
            dv_q[0] <= vld_q;
            dp_q[0] <= par_q;
            for (int i = 1; i < PE_LATENCY; i++) begin
                dv_q[i] <= dv_q[i-1];
                dp_q[i] <= dp_q[i-1];
            end
        end
    end

    assign rd_req         = req_q;
    assign rd_addr        = addr_q;
    assign data_parameter = par_q;
    assign data_in_bx0    = bx_q;
    assign data_in_by0    = by_q;
    assign data_in_bw0    = bw_q;
    assign data_in_bh0    = bh_q;
    assign pe_in_valid    = vld_q;
    assign pe_out_valid   = dv_q[PE_LATENCY-1];
    assign pe_out_param   = dp_q[PE_LATENCY-1];
    assign busy           = busy_q;
    assign done           = done_q;
endmodule
